hazard_stall_ctrl: RTL and testbench

- Pipeline-wide hazard and stall controller for the 5-stage core.
- Replaces single-cycle load-use detection with a parametrised unit that:
  - detects RAW hazards against ID/EX, EX/MEM and MEM/WB, in forwarding or non-forwarding mode;
  - freezes the whole pipeline for multi-cycle data-memory accesses via an internal wait FSM;
  - arbitrates branch-mispredict flushes;
  - keeps saturating stall/flush performance counters.

---
 rtl/hazard_pkg.sv | 19 +
 rtl/mem_wait_fsm.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 84 ++++++++
 tb/tb_hazard_stall_ctrl.sv | 261 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_pkg.sv
// hazard_pkg: shared FSM encodings, register-zero constant and stage-control bundle
package hazard_pkg;
    typedef enum logic {ST_IDLE = 1'b0, ST_WAIT = 1'b1} wait_state_t;
    localparam int REG_ZERO = 0;
    typedef struct packed {
        logic pc_write;
        logic if_id_write;
        logic if_id_flush;
        logic id_ex_write;
        logic id_ex_flush;
        logic ex_mem_write;
        logic mem_wb_bubble;
        logic mem_busy;
    } stage_ctrl_t;
    localparam stage_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_FREEZE = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    localparam stage_ctrl_t CTRL_FLUSH  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam stage_ctrl_t CTRL_STALL  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
endpackage

// File: rtl/mem_wait_fsm.sv
// mem_wait_fsm: holds the pipeline while a data-memory access occupies MEM for MEM_LATENCY cycles
module mem_wait_fsm
    import hazard_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic clk,
    input  logic reset_n,
    input  logic mem_op,
    output logic freeze
);
    localparam logic       MULTI    = MEM_LATENCY > 1;
    localparam logic [3:0] CNT_INIT = 4'(MEM_LATENCY > 1 ? MEM_LATENCY - 2 : 0);
    wait_state_t state;
    logic [3:0]  cnt;
    assign freeze = (state == ST_IDLE) ? (mem_op && MULTI) : (cnt != 4'd0);
    // IDLE launches a wait on a multi-cycle access; WAIT counts down and releases at zero
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= ST_IDLE;
            cnt   <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (mem_op && MULTI) begin
                state <= ST_WAIT;
                cnt   <= CNT_INIT;
            end
        end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
        end else begin
            state <= ST_IDLE;
        end
    end
endmodule

// File: rtl/hazard_stall_ctrl.sv
// hazard_stall_ctrl: RAW detection, memory freeze, mispredict flush and stall/flush counters
module hazard_stall_ctrl
    import hazard_pkg::*;
#(
    parameter int REG_AW       = 5,
    parameter int MEM_LATENCY  = 1,
    parameter bit FORWARD_EN   = 1'b1,
    parameter bit RF_WB_BYPASS = 1'b1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [REG_AW-1:0] rs1,
    input  logic [REG_AW-1:0] rs2,
    input  logic              use_rs1,
    input  logic              use_rs2,
    input  logic [REG_AW-1:0] id_ex_rd,
    input  logic [REG_AW-1:0] ex_mem_rd,
    input  logic [REG_AW-1:0] mem_wb_rd,
    input  logic              id_ex_reg_write,
    input  logic              ex_mem_reg_write,
    input  logic              mem_wb_reg_write,
    input  logic              id_ex_mem_read,
    input  logic              ex_mem_mem_read,
    input  logic              ex_mem_mem_write,
    input  logic              branch_mispredict,
    input  logic              perf_clr,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              if_id_flush,
    output logic              id_ex_write,
    output logic              id_ex_flush,
    output logic              ex_mem_write,
    output logic              mem_wb_bubble,
    output logic              mem_busy,
    output logic [CNT_W-1:0]  stall_cycles,
    output logic [CNT_W-1:0]  flush_count
);
    logic        freeze, raw_hazard, stall_inc, flush_inc;
    stage_ctrl_t ctrl;
    function automatic logic stage_hit(input logic [REG_AW-1:0] rd, input logic wr);
        return wr && rd != REG_AW'(REG_ZERO) &&
               ((use_rs1 && rs1 == rd) || (use_rs2 && rs2 == rd));
    endfunction
    mem_wait_fsm #(.MEM_LATENCY(MEM_LATENCY)) u_wait (
        .clk    (clk),
        .reset_n(reset_n),
        .mem_op (ex_mem_mem_read | ex_mem_mem_write),
        .freeze (freeze)
    );
    // RAW detection and fixed-priority selection of the stage-control bundle
    always_comb begin
        raw_hazard = FORWARD_EN ? stage_hit(id_ex_rd, id_ex_mem_read)
                                : stage_hit(id_ex_rd, id_ex_reg_write) ||
                                  stage_hit(ex_mem_rd, ex_mem_reg_write) ||
                                  (!RF_WB_BYPASS && stage_hit(mem_wb_rd, mem_wb_reg_write));
        ctrl = freeze            ? CTRL_FREEZE :
               branch_mispredict ? CTRL_FLUSH  :
               raw_hazard        ? CTRL_STALL  : CTRL_RUN;
        stall_inc = freeze || (raw_hazard && !branch_mispredict);
        flush_inc = !freeze && branch_mispredict;
    end
    assign pc_write      = ctrl.pc_write;
    assign if_id_write   = ctrl.if_id_write;
    assign if_id_flush   = ctrl.if_id_flush;
    assign id_ex_write   = ctrl.id_ex_write;
    assign id_ex_flush   = ctrl.id_ex_flush;
    assign ex_mem_write  = ctrl.ex_mem_write;
    assign mem_wb_bubble = ctrl.mem_wb_bubble;
    assign mem_busy      = ctrl.mem_busy;
    // Saturating performance counters; clear wins over increment
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else if (perf_clr) begin
            stall_cycles <= '0;
            flush_count  <= '0;
        end else begin
            if (stall_inc && stall_cycles != '1) stall_cycles <= stall_cycles + CNT_W'(1);
            if (flush_inc && flush_count != '1) flush_count <= flush_count + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_hazard_stall_ctrl.sv
// tb_hazard_stall_ctrl: directed scoreboard bench over three parameterisations of hazard_stall_ctrl
module tb_hazard_stall_ctrl;
    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [4:0] rs1, rs2, id_ex_rd, ex_mem_rd, mem_wb_rd;
    logic       use_rs1, use_rs2, id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write;
    logic       id_ex_mem_read, ex_mem_mem_read, ex_mem_mem_write, branch_mispredict, perf_clr;
    wire [7:0]  c0, c1, c2;
    wire [15:0] st0, fc0, st2, fc2;
    wire [3:0]  st1, fc1;
    int         total = 0;
    int         bad = 0;

    localparam logic [7:0] RUN    = 8'b1101_0100;
    localparam logic [7:0] FREEZE = 8'b0000_0011;
    localparam logic [7:0] FLUSH  = 8'b1111_1100;
    localparam logic [7:0] STALL  = 8'b0001_1100;

    typedef struct {
        string       tag;
        int          d;
        int          s;
        logic [15:0] v;
    } exp_t;
    exp_t sb[$];

    always #5 clk = ~clk;

    hazard_stall_ctrl #(.FORWARD_EN(1'b1), .RF_WB_BYPASS(1'b1), .MEM_LATENCY(1), .CNT_W(16)) u0 (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_reg_write(id_ex_reg_write), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_reg_write(mem_wb_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .branch_mispredict(branch_mispredict), .perf_clr(perf_clr),
        .pc_write(c0[7]), .if_id_write(c0[6]), .if_id_flush(c0[5]), .id_ex_write(c0[4]),
        .id_ex_flush(c0[3]), .ex_mem_write(c0[2]), .mem_wb_bubble(c0[1]), .mem_busy(c0[0]),
        .stall_cycles(st0), .flush_count(fc0));

    hazard_stall_ctrl #(.FORWARD_EN(1'b0), .RF_WB_BYPASS(1'b0), .MEM_LATENCY(4), .CNT_W(4)) u1 (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_reg_write(id_ex_reg_write), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_reg_write(mem_wb_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .branch_mispredict(branch_mispredict), .perf_clr(perf_clr),
        .pc_write(c1[7]), .if_id_write(c1[6]), .if_id_flush(c1[5]), .id_ex_write(c1[4]),
        .id_ex_flush(c1[3]), .ex_mem_write(c1[2]), .mem_wb_bubble(c1[1]), .mem_busy(c1[0]),
        .stall_cycles(st1), .flush_count(fc1));

    hazard_stall_ctrl #(.FORWARD_EN(1'b0), .RF_WB_BYPASS(1'b1), .MEM_LATENCY(3), .CNT_W(16)) u2 (
        .clk(clk), .reset_n(reset_n), .rs1(rs1), .rs2(rs2), .use_rs1(use_rs1), .use_rs2(use_rs2),
        .id_ex_rd(id_ex_rd), .ex_mem_rd(ex_mem_rd), .mem_wb_rd(mem_wb_rd),
        .id_ex_reg_write(id_ex_reg_write), .ex_mem_reg_write(ex_mem_reg_write),
        .mem_wb_reg_write(mem_wb_reg_write), .id_ex_mem_read(id_ex_mem_read),
        .ex_mem_mem_read(ex_mem_mem_read), .ex_mem_mem_write(ex_mem_mem_write),
        .branch_mispredict(branch_mispredict), .perf_clr(perf_clr),
        .pc_write(c2[7]), .if_id_write(c2[6]), .if_id_flush(c2[5]), .id_ex_write(c2[4]),
        .id_ex_flush(c2[3]), .ex_mem_write(c2[2]), .mem_wb_bubble(c2[1]), .mem_busy(c2[0]),
        .stall_cycles(st2), .flush_count(fc2));

    function automatic logic [15:0] obs(input int d, input int s);
        if (d == 0) return s == 0 ? {8'h00, c0} : s == 1 ? st0 : fc0;
        if (d == 1) return s == 0 ? {8'h00, c1} : s == 1 ? {12'h000, st1} : {12'h000, fc1};
        return s == 0 ? {8'h00, c2} : s == 1 ? st2 : fc2;
    endfunction

    task automatic push_exp(input string tag, input int d, input int s, input logic [15:0] v);
        exp_t e;
        e.tag = tag;
        e.d = d;
        e.s = s;
        e.v = v;
        sb.push_back(e);
    endtask

    task automatic check();
        while (sb.size() > 0) begin
            exp_t e;
            logic [15:0] o;
            e = sb.pop_front();
            o = obs(e.d, e.s);
            total++;
            assert (o === e.v) else begin
                bad++;
                $error("FAIL %s u%0d: observed=%0h expected=%0h", e.tag, e.d, o, e.v);
            end
        end
    endtask

    task automatic step();
        @(negedge clk);
        check();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        {rs1, rs2, id_ex_rd, ex_mem_rd, mem_wb_rd} = '0;
        {use_rs1, use_rs2, id_ex_reg_write, ex_mem_reg_write, mem_wb_reg_write} = '0;
        {id_ex_mem_read, ex_mem_mem_read, ex_mem_mem_write, branch_mispredict, perf_clr} = '0;
    endtask

    task automatic ex_mem_raw();
        idle();
        ex_mem_reg_write = 1'b1;
        ex_mem_rd = 5'd7;
        rs1 = 5'd7;
        use_rs1 = 1'b1;
    endtask

    task automatic load_use(input logic [4:0] rd);
        idle();
        id_ex_mem_read = 1'b1;
        id_ex_reg_write = 1'b1;
        id_ex_rd = rd;
        rs2 = 5'd5;
        use_rs2 = 1'b1;
    endtask

    initial begin
        idle();
        #12 reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp("reset ctrl", 0, 0, RUN);
        push_exp("reset ctrl", 1, 0, RUN);
        push_exp("reset ctrl", 2, 0, RUN);
        push_exp("reset stall", 0, 1, 0);
        push_exp("reset flush", 1, 2, 0);
        step();
        load_use(5'd5);
        push_exp("load-use", 0, 0, STALL);
        push_exp("load-use nofwd", 1, 0, STALL);
        push_exp("load-use nofwd", 2, 0, STALL);
        step();
        load_use(5'd0);
        push_exp("load-use rd0", 0, 0, RUN);
        push_exp("load-use rd0", 1, 0, RUN);
        push_exp("stall cnt lu", 0, 1, 1);
        step();
        ex_mem_raw();
        push_exp("exmem fwd", 0, 0, RUN);
        push_exp("exmem raw", 1, 0, STALL);
        push_exp("exmem raw", 2, 0, STALL);
        step();
        idle();
        mem_wb_reg_write = 1'b1;
        mem_wb_rd = 5'd7;
        rs1 = 5'd7;
        use_rs1 = 1'b1;
        push_exp("memwb fwd", 0, 0, RUN);
        push_exp("memwb nobyp", 1, 0, STALL);
        push_exp("memwb byp", 2, 0, RUN);
        step();
        use_rs1 = 1'b0;
        push_exp("memwb unused", 1, 0, RUN);
        push_exp("stall cnt raw", 1, 1, 3);
        push_exp("stall cnt raw", 2, 1, 2);
        step();
        use_rs1 = 1'b1;
        rs1 = 5'd0;
        mem_wb_rd = 5'd0;
        push_exp("memwb r0", 1, 0, RUN);
        push_exp("memwb r0", 2, 0, RUN);
        step();
        load_use(5'd5);
        branch_mispredict = 1'b1;
        push_exp("mispredict+lu", 0, 0, FLUSH);
        push_exp("mispredict+lu", 1, 0, FLUSH);
        push_exp("mispredict+lu", 2, 0, FLUSH);
        step();
        idle();
        push_exp("after flush", 0, 0, RUN);
        push_exp("flush cnt", 0, 2, 1);
        push_exp("stall cnt kept", 0, 1, 1);
        step();
        perf_clr = 1'b1;
        push_exp("clr ctrl", 0, 0, RUN);
        step();
        idle();
        ex_mem_mem_read = 1'b1;
        push_exp("clr stall", 0, 1, 0);
        push_exp("clr flush", 0, 2, 0);
        push_exp("lat1 mem", 0, 0, RUN);
        push_exp("lat4 c0", 1, 0, FREEZE);
        push_exp("lat3 c0", 2, 0, FREEZE);
        step();
        push_exp("lat4 c1", 1, 0, FREEZE);
        push_exp("lat3 c1", 2, 0, FREEZE);
        step();
        push_exp("lat4 c2", 1, 0, FREEZE);
        push_exp("lat3 release", 2, 0, RUN);
        step();
        push_exp("lat4 release", 1, 0, RUN);
        push_exp("lat3 b2b", 2, 0, FREEZE);
        step();
        push_exp("lat4 b2b", 1, 0, FREEZE);
        push_exp("lat3 b2b c1", 2, 0, FREEZE);
        step();
        idle();
        push_exp("lat4 hold", 1, 0, FREEZE);
        push_exp("lat3 b2b rel", 2, 0, RUN);
        step();
        branch_mispredict = 1'b1;
        push_exp("mp frozen", 1, 0, FREEZE);
        push_exp("mp free", 2, 0, FLUSH);
        push_exp("mp free", 0, 0, FLUSH);
        step();
        push_exp("mp on release", 1, 0, FLUSH);
        step();
        idle();
        push_exp("stall cnt mem", 1, 1, 6);
        push_exp("flush cnt mem", 1, 2, 1);
        push_exp("stall cnt mem", 2, 1, 4);
        push_exp("flush cnt mem", 2, 2, 2);
        push_exp("flush cnt mem", 0, 2, 2);
        step();
        for (int i = 0; i < 12; i++) begin
            ex_mem_raw();
            push_exp("sat stall", 1, 0, STALL);
            step();
        end
        idle();
        push_exp("stall sat", 1, 1, 16'h000f);
        step();
        ex_mem_raw();
        perf_clr = 1'b1;
        push_exp("clr+stall", 1, 0, STALL);
        push_exp("stall sat hold", 1, 1, 16'h000f);
        step();
        idle();
        push_exp("clr prio", 1, 1, 0);
        push_exp("clr prio", 2, 1, 0);
        step();
        ex_mem_mem_read = 1'b1;
        push_exp("pre-rst freeze", 1, 0, FREEZE);
        step();
        idle();
        push_exp("pre-rst wait", 1, 0, FREEZE);
        push_exp("pre-rst wait", 2, 0, FREEZE);
        push_exp("pre-rst cnt", 1, 1, 1);
        @(negedge clk);
        check();
        #2 reset_n = 1'b0;
        #1;
        push_exp("async rst", 1, 0, RUN);
        push_exp("async rst", 2, 0, RUN);
        push_exp("async rst cnt", 1, 1, 0);
        push_exp("async rst cnt", 2, 1, 0);
        check();
        #1 reset_n = 1'b1;
        @(posedge clk);
        #1;
        push_exp("post rst", 1, 0, RUN);
        push_exp("post rst", 2, 0, RUN);
        step();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
